ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the decode/register-file stage. Owns the PC and issues word reads to the instruction memory, which has variable latency of at least one cycle. Presents one fetched instruction, with its PC, to decode under a valid/stall handshake. Accepts redirects (taken branch, jal, jalr, trap) from execute, squashes in-flight fetches, and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
ADDR_W, 14, imem word-address width; imem_addr = pc[ADDR_W+1:2].

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-low reset
imem_req  out  1  read request strobe, exactly one cycle per fetch
imem_addr  out  ADDR_W  word address, valid while imem_req=1
imem_rdata  in  32  read data, valid when imem_ack=1
imem_ack  in  1  read-complete pulse, one per request
redirect_valid  in  1  load redirect_target as the next PC
redirect_target  in  32  byte address of the redirect
stall  in  1  decode not ready; holds the presented instruction
inst_valid  out  1  inst/pc hold a live instruction
inst  out  32  instruction to decode
pc  out  32  address of inst
pc_plus4  out  32  pc + 4, link value for jal/jalr
misalign_fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Reset (rst=0 at posedge) dominates everything. state=REQ, pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, misalign_fault=0, squash=0, imem_req=0. Reset mid-WAIT discards any later ack belonging to the old request.
- Outputs are registered except imem_req=(state==REQ) and imem_addr=pc[ADDR_W+1:2].
- States:
  - REQ: imem_req=1 for one cycle, then go to WAIT. imem_ack is ignored in REQ.
  - WAIT: on imem_ack with squash=0, latch inst=imem_rdata, set inst_valid=1, go to HOLD. On imem_ack with squash=1, discard the data, clear squash, go to REQ.
  - HOLD: inst, pc and inst_valid are held while stall=1. On the first posedge with stall=0 the instruction is consumed: pc<=pc+4, inst_valid<=0, go to REQ.
  - FAULT: inst_valid=0, imem_req=0. Only reset exits FAULT.
- Redirect (redirect_valid=1) takes priority over stall and over consumption.
  - Target aligned (target[1:0]==0):
    - pc<=target, inst_valid<=0.
    - In HOLD, go to REQ.
    - In REQ or WAIT, set squash=1 and go to (or stay in) WAIT. If ack arrives in the same cycle, drop it and go to REQ with squash=0.
  - Target misaligned: misalign_fault<=1, inst_valid<=0, pc<=target, go to FAULT.
- Arithmetic: pc+4 wraps modulo 2^32. pc_plus4 is combinational from pc. pc bits above ADDR_W+1 are not checked.
- Latency: REQ, then WAIT with ack at the earliest one cycle later, then HOLD. Minimum is 3 cycles per instruction with no stall and a 1-cycle imem.
- At most one imem request is outstanding. Hence the squash flag rather than a counter.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INST = 32'h0000_0013.
  - Default RESET_PC.
  - Enum fetch_state_t {REQ, WAIT, HOLD, FAULT}.
  - Function is_aligned(addr).
- No sub-module. This is a single FSM plus the PC register.

Test Plan:
- Reset, then release with an imem of 1-cycle ack returning 0x00500093 at addr 0, stall=0 -> imem_req pulses at addr 0; inst_valid=1 with inst=0x00500093, pc=0, pc_plus4=4; next imem_addr=1.
- Straight line of 4 instructions with stall=0 and 1-cycle imem -> pc sequence 0, 4, 8, 12 with inst_valid high every 3rd cycle; then 3-cycle ack latency -> WAIT holds and pc is unchanged until ack.
- stall=1 for 5 cycles in HOLD -> inst, pc and inst_valid are constant and no imem_req. Stall released -> pc advances by 4 exactly once.
- Redirect to 0x40 in HOLD with stall=1 -> inst_valid drops the next cycle, imem_addr=0x10, the old instruction is never re-presented.
- Redirect to 0x80 in WAIT, with ack two cycles later carrying 0xDEADBEEF -> 0xDEADBEEF is never presented; a new request is issued at word 0x20; the instruction from 0x80 is presented with pc=0x80.
- Redirect to 0x42 -> misalign_fault=1, inst_valid=0, no further imem_req. Assert rst=0 mid-FAULT -> pc=RESET_PC, misalign_fault=0, fetching resumes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset defaults and the NOP encoding
// used to fill the instruction register while nothing live is held.
package cpu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_ADDR_W   = 14;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr & 32'h3) == 32'h0;
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read at a time and holds the
// fetched word for decode until it is consumed or a redirect replaces it.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  input  logic              stall,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              misalign_fault,
  output fetch_state_t      state_dbg
);

  // Handshake: imem_req is a one-cycle strobe per fetch and exactly one imem_ack
  // answers it; decode takes inst/pc on the first cycle with inst_valid=1 and
  // stall=0, and redirect_valid is honoured on every cycle outside FAULT.

  fetch_state_t state;
  logic         squash;

  // No request is issued while reset is held.
  assign imem_req  = rst && (state == REQ);
  assign imem_addr = pc[ADDR_W+1:2];
  assign pc_plus4  = pc + 32'd4;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= REQ;
      pc             <= RESET_PC;
      inst           <= NOP_INST;
      inst_valid     <= 1'b0;
      misalign_fault <= 1'b0;
      squash         <= 1'b0;
    end else if (redirect_valid && state != FAULT) begin
      pc         <= redirect_target;
      inst_valid <= 1'b0;
      if (!is_aligned(redirect_target)) begin
        misalign_fault <= 1'b1;
        squash         <= 1'b0;
        state          <= FAULT;
      end else if (state == HOLD) begin
        state <= REQ;
      end else if (state == WAIT && imem_ack) begin
        // The outstanding read completes right now, so nothing is left to squash.
        squash <= 1'b0;
        state  <= REQ;
      end else begin
        squash <= 1'b1;
        state  <= WAIT;
      end
    end else begin
      case (state)
        REQ: state <= WAIT;
        WAIT: begin
          if (imem_ack) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= REQ;
            end else begin
              inst       <= imem_rdata;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc         <= pc_plus4;
            inst_valid <= 1'b0;
            state      <= REQ;
          end
        end
        FAULT:   inst_valid <= 1'b0;
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a cycle table for reset, straight-line fetch and
// stall, then hand-written sequences for redirects, squash, fault and reset.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [13:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_ack;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         stall;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         misalign_fault;
  fetch_state_t state_dbg;

  int tests = 0;
  int fails = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_fault(misalign_fault), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Instruction memory model: an ack arrives lat cycles after the request cycle.
  logic [31:0] mem [0:255];
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [7:0]  paddr = 8'h0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      imem_ack = 1'b0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[paddr];
          pend       = 1'b0;
        end
      end
      if (imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr[7:0];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        req;
    logic [13:0] addr;
    logic        iv;
    logic [31:0] inst;
    logic        chk;
    logic [31:0] pc;
    logic        fault;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic rv,
                              input logic [31:0] rt, input logic req,
                              input logic [13:0] addr, input logic iv,
                              input logic [31:0] ins, input logic chk,
                              input logic [31:0] p, input logic f);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.rt = rt;
    v.req = req; v.addr = addr; v.iv = iv; v.inst = ins; v.chk = chk;
    v.pc = p; v.fault = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge, then compare outputs.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst             = v.rst;
    stall           = v.stall;
    redirect_valid  = v.rv;
    redirect_target = v.rt;
    #1;
    check({tag, " imem_req"},   {31'h0, imem_req},       {31'h0, v.req});
    check({tag, " imem_addr"},  {18'h0, imem_addr},      {18'h0, v.addr});
    check({tag, " inst_valid"}, {31'h0, inst_valid},     {31'h0, v.iv});
    check({tag, " pc"},         pc,                      v.pc);
    check({tag, " pc_plus4"},   pc_plus4,                v.pc + 32'd4);
    check({tag, " fault"},      {31'h0, misalign_fault}, {31'h0, v.fault});
    if (v.chk) check({tag, " inst"}, inst, v.inst);
  endtask

  vec_t tbl [0:18];
  vec_t h [0:31];

  initial begin
    rst             = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]     = 32'h0050_0093;
    mem[8'h11] = 32'hDEAD_BEEF;

    //                 rst s  rv rt     req addr iv inst          chk pc  flt
    tbl[0]  = mk(1'b0, 0, 0, 0,     0, 0,   0, NOP,          1, 0,  0);
    tbl[1]  = mk(1'b1, 0, 0, 0,     1, 0,   0, 0,            0, 0,  0);
    tbl[2]  = mk(1'b1, 0, 0, 0,     0, 0,   0, 0,            0, 0,  0);
    tbl[3]  = mk(1'b1, 0, 0, 0,     0, 0,   1, 32'h00500093, 1, 0,  0);
    tbl[4]  = mk(1'b1, 0, 0, 0,     1, 1,   0, 0,            0, 4,  0);
    tbl[5]  = mk(1'b1, 0, 0, 0,     0, 1,   0, 0,            0, 4,  0);
    tbl[6]  = mk(1'b1, 0, 0, 0,     0, 1,   1, 32'h10000001, 1, 4,  0);
    tbl[7]  = mk(1'b1, 0, 0, 0,     1, 2,   0, 0,            0, 8,  0);
    tbl[8]  = mk(1'b1, 0, 0, 0,     0, 2,   0, 0,            0, 8,  0);
    tbl[9]  = mk(1'b1, 0, 0, 0,     0, 2,   1, 32'h10000002, 1, 8,  0);
    tbl[10] = mk(1'b1, 0, 0, 0,     1, 3,   0, 0,            0, 12, 0);
    tbl[11] = mk(1'b1, 0, 0, 0,     0, 3,   0, 0,            0, 12, 0);
    for (int i = 12; i < 17; i++)
      tbl[i] = mk(1'b1, 1, 0, 0,    0, 3,   1, 32'h10000003, 1, 12, 0);
    tbl[17] = mk(1'b1, 0, 0, 0,     0, 3,   1, 32'h10000003, 1, 12, 0);
    tbl[18] = mk(1'b1, 0, 0, 0,     1, 4,   0, 0,            0, 16, 0);

    // Redirect in HOLD under stall, 3-cycle imem, redirect in WAIT with a stale ack,
    // redirect coinciding with ack, misaligned redirect, reset from FAULT and mid-WAIT.
    h[0]  = mk(1, 0, 0, 0,      0, 14'h04, 0, 0,            0, 32'h10,  0);
    h[1]  = mk(1, 1, 1, 32'h40, 0, 14'h04, 1, 32'h10000004, 1, 32'h10,  0);
    h[2]  = mk(1, 1, 0, 0,      1, 14'h10, 0, 0,            0, 32'h40,  0);
    h[3]  = mk(1, 0, 0, 0,      0, 14'h10, 0, 0,            0, 32'h40,  0);
    h[4]  = mk(1, 0, 0, 0,      0, 14'h10, 0, 0,            0, 32'h40,  0);
    h[5]  = mk(1, 0, 0, 0,      0, 14'h10, 0, 0,            0, 32'h40,  0);
    h[6]  = mk(1, 0, 0, 0,      0, 14'h10, 1, 32'h10000010, 1, 32'h40,  0);
    h[7]  = mk(1, 0, 0, 0,      1, 14'h11, 0, 0,            0, 32'h44,  0);
    h[8]  = mk(1, 0, 1, 32'h80, 0, 14'h11, 0, 0,            0, 32'h44,  0);
    h[9]  = mk(1, 0, 0, 0,      0, 14'h20, 0, 0,            0, 32'h80,  0);
    h[10] = mk(1, 0, 0, 0,      0, 14'h20, 0, 0,            0, 32'h80,  0);
    h[11] = mk(1, 0, 0, 0,      1, 14'h20, 0, 0,            0, 32'h80,  0);
    h[12] = mk(1, 0, 0, 0,      0, 14'h20, 0, 0,            0, 32'h80,  0);
    h[13] = mk(1, 0, 0, 0,      0, 14'h20, 1, 32'h10000020, 1, 32'h80,  0);
    h[14] = mk(1, 0, 0, 0,      1, 14'h21, 0, 0,            0, 32'h84,  0);
    h[15] = mk(1, 0, 1, 32'h100,0, 14'h21, 0, 0,            0, 32'h84,  0);
    h[16] = mk(1, 0, 0, 0,      1, 14'h40, 0, 0,            0, 32'h100, 0);
    h[17] = mk(1, 0, 0, 0,      0, 14'h40, 0, 0,            0, 32'h100, 0);
    h[18] = mk(1, 0, 1, 32'h42, 0, 14'h40, 1, 32'h10000040, 1, 32'h100, 0);
    h[19] = mk(1, 0, 0, 0,      0, 14'h10, 0, 0,            0, 32'h42,  1);
    h[20] = mk(1, 0, 1, 32'h0,  0, 14'h10, 0, 0,            0, 32'h42,  1);
    h[21] = mk(1, 0, 0, 0,      0, 14'h10, 0, 0,            0, 32'h42,  1);
    h[22] = mk(0, 0, 0, 0,      0, 14'h10, 0, 0,            0, 32'h42,  1);
    h[23] = mk(1, 0, 0, 0,      1, 14'h00, 0, NOP,          1, 32'h0,   0);
    h[24] = mk(1, 0, 0, 0,      0, 14'h00, 0, 0,            0, 32'h0,   0);
    h[25] = mk(1, 0, 0, 0,      0, 14'h00, 1, 32'h00500093, 1, 32'h0,   0);
    h[26] = mk(1, 0, 0, 0,      1, 14'h01, 0, 0,            0, 32'h4,   0);
    h[27] = mk(1, 0, 0, 0,      0, 14'h01, 0, 0,            0, 32'h4,   0);
    h[28] = mk(0, 0, 0, 0,      0, 14'h01, 0, 0,            0, 32'h4,   0);
    h[29] = mk(1, 0, 0, 0,      1, 14'h00, 0, NOP,          1, 32'h0,   0);
    h[30] = mk(1, 0, 0, 0,      0, 14'h00, 0, 0,            0, 32'h0,   0);
    h[31] = mk(1, 0, 0, 0,      0, 14'h00, 1, 32'h00500093, 1, 32'h0,   0);

    repeat (3) @(posedge clk);

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 32; i++) begin
      apply(h[i], $sformatf("seq%0d", i));
      if (i == 1)  lat = 3;
      if (i == 10) lat = 1;
      if (i == 19) check("seq19 state", {30'h0, state_dbg}, {30'h0, FAULT});
      if (i == 25) lat = 3;
      if (i == 28) lat = 1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
